adc_capture_gate: RTL and testbench

- Per-channel front end in the rf_clk domain, between an RF data converter ADC AXI-Stream output and the per-channel rounding/FIFO input of the ADC-to-DDR capture path.
- Arms on software command and waits for a software or threshold-crossing trigger. It then forwards exactly cap_beats ADC beats downstream, asserting tlast on the final beat.
- ADC data cannot be stalled. Beats that arrive while the output register is blocked are dropped and flagged.

---
 rtl/adc_capture_pkg.sv | 23 ++
 rtl/adc_trig_detect.sv | 56 +++++
 rtl/adc_capture_gate.sv | 197 +++++++++++++++++++
 tb/tb_adc_capture_gate.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types and helpers for the ADC capture gate.
// Sample width, default lane count, FSM states, signed crossing test.
package adc_capture_pkg;

  localparam int SAMP_W    = 16;
  localparam int NSAMP_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } cap_state_t;

  function automatic logic xing_f(
    input logic signed [SAMP_W-1:0] cur,
    input logic signed [SAMP_W-1:0] prv,
    input logic signed [SAMP_W-1:0] thr
  );
    return (cur > thr) && (prv <= thr);
  endfunction

endpackage

// File: rtl/adc_trig_detect.sv
// Input stage: registers each ADC beat and flags an upward
// threshold crossing, including across the beat boundary.
module adc_trig_detect
  import adc_capture_pkg::*;
#(
  parameter int NSAMP = NSAMP_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tvalid,
  input  logic [SAMP_W*NSAMP-1:0] tdata,
  input  logic [SAMP_W-1:0]       threshold,
  output logic                    valid_q,
  output logic [SAMP_W*NSAMP-1:0] data_q,
  output logic                    xing_q
);

  localparam int DW = SAMP_W * NSAMP;

  logic [SAMP_W-1:0]    prev;
  logic [DW+SAMP_W-1:0] ext;
  logic [SAMP_W-1:0]    cur;
  logic [SAMP_W-1:0]    lst;
  logic                 xing;

  // prev sits below sample 0 so sample i compares against slot i
  assign ext = {tdata, prev};

  always_comb begin
    xing = 1'b0;
    cur  = '0;
    lst  = '0;
    for (int i = 0; i < NSAMP; i++) begin
      cur  = ext[(i+1)*SAMP_W +: SAMP_W];
      lst  = ext[i*SAMP_W +: SAMP_W];
      xing = xing | xing_f(cur, lst, threshold);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      xing_q  <= 1'b0;
      prev    <= '0;
    end else begin
      valid_q <= tvalid;
      xing_q  <= tvalid & xing;
      if (tvalid) begin
        data_q <= tdata;
        prev   <= tdata[DW-1 -: SAMP_W];
      end
    end
  end

endmodule

// File: rtl/adc_capture_gate.sv
// Armed/triggered capture gate for one ADC stream channel.
// ADC_CAPTURE_GATE_DROP_CNT_EN adds a saturating drop_cnt port.
module adc_capture_gate
  import adc_capture_pkg::*;
#(
  parameter int NSAMP = NSAMP_DEF,
  parameter int CNT_W = 32
) (
  input  logic                    rf_clk,
  input  logic                    rf_rstb,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [SAMP_W*NSAMP-1:0] s_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [SAMP_W*NSAMP-1:0] m_axis_tdata,
  output logic                    m_axis_tlast,
  input  logic                    arm,
  input  logic                    abort,
  input  logic                    sw_trig,
  input  logic                    trig_mode,
  input  logic [SAMP_W-1:0]       threshold,
  input  logic [CNT_W-1:0]        cap_beats,
  output logic                    busy,
  output logic                    cap_done,
  output logic                    overflow
`ifdef ADC_CAPTURE_GATE_DROP_CNT_EN
  ,
  output logic [15:0]             drop_cnt
`endif
);

  localparam int DW = SAMP_W * NSAMP;

  logic             valid_q;
  logic             xing_q;
  logic [DW-1:0]    data_q;

  cap_state_t       state;
  cap_state_t       state_nx;
  logic [CNT_W-1:0] cap_len;
  logic [CNT_W-1:0] cap_len_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             pend;
  logic             pend_nx;
  logic             out_v;
  logic             out_v_nx;
  logic             out_l;
  logic             out_l_nx;
  logic [DW-1:0]    out_d;
  logic [DW-1:0]    out_d_nx;
  logic             done;
  logic             done_nx;
  logic             ovf;
  logic             ovf_nx;
  logic             rdy;
  logic             drain;
  logic             fire;
  logic             beat;
  logic             hit_last;
`ifdef ADC_CAPTURE_GATE_DROP_CNT_EN
  logic [15:0]      drops;
  logic [15:0]      drops_nx;
`endif

  adc_trig_detect #(
    .NSAMP(NSAMP)
  ) u_det (
    .clk      (rf_clk),
    .rst_n    (rf_rstb),
    .tvalid   (s_axis_tvalid),
    .tdata    (s_axis_tdata),
    .threshold(threshold),
    .valid_q  (valid_q),
    .data_q   (data_q),
    .xing_q   (xing_q)
  );

  assign drain = out_v & m_axis_tready;

  always_comb begin
    state_nx   = state;
    cap_len_nx = cap_len;
    cnt_nx     = cnt;
    pend_nx    = pend;
    out_v_nx   = out_v;
    out_l_nx   = out_l;
    out_d_nx   = out_d;
    done_nx    = done;
    ovf_nx     = ovf;
    fire       = 1'b0;
    beat       = 1'b0;
    hit_last   = 1'b0;
`ifdef ADC_CAPTURE_GATE_DROP_CNT_EN
    drops_nx   = drops;
`endif
    if (drain) begin
      out_v_nx = 1'b0;
      out_l_nx = 1'b0;
    end
    unique case (state)
      IDLE: begin
        if (arm && (cap_beats != '0)) begin
          cap_len_nx = cap_beats;
          cnt_nx     = '0;
          pend_nx    = 1'b0;
          done_nx    = 1'b0;
          ovf_nx     = 1'b0;
`ifdef ADC_CAPTURE_GATE_DROP_CNT_EN
          drops_nx   = '0;
`endif
          state_nx   = ARMED;
        end
      end
      ARMED: begin
        if (sw_trig) pend_nx = 1'b1;
        fire = valid_q & ((xing_q & trig_mode) | sw_trig | pend);
        if (fire) pend_nx = 1'b0;
        beat = fire;
      end
      CAPTURE: beat = valid_q;
      DONE: begin
        if (!out_v || drain) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
    endcase
    // dropped beats still advance the count so capture length is fixed
    if (beat) begin
      cnt_nx   = cnt + 1'b1;
      hit_last = (cnt_nx == cap_len);
      if (!out_v || drain) begin
        out_v_nx = 1'b1;
        out_d_nx = data_q;
        out_l_nx = hit_last;
      end else begin
        ovf_nx = 1'b1;
`ifdef ADC_CAPTURE_GATE_DROP_CNT_EN
        if (drops != 16'hFFFF) drops_nx = drops + 16'd1;
`endif
      end
      state_nx = hit_last ? DONE : CAPTURE;
    end
    if (abort) begin
      state_nx = IDLE;
      pend_nx  = 1'b0;
      out_v_nx = 1'b0;
      out_l_nx = 1'b0;
    end
  end

  always_ff @(posedge rf_clk or negedge rf_rstb) begin
    if (!rf_rstb) begin
      state   <= IDLE;
      cap_len <= '0;
      cnt     <= '0;
      pend    <= 1'b0;
      out_v   <= 1'b0;
      out_l   <= 1'b0;
      out_d   <= '0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      rdy     <= 1'b0;
`ifdef ADC_CAPTURE_GATE_DROP_CNT_EN
      drops   <= '0;
`endif
    end else begin
      state   <= state_nx;
      cap_len <= cap_len_nx;
      cnt     <= cnt_nx;
      pend    <= pend_nx;
      out_v   <= out_v_nx;
      out_l   <= out_l_nx;
      out_d   <= out_d_nx;
      done    <= done_nx;
      ovf     <= ovf_nx;
      rdy     <= 1'b1;
`ifdef ADC_CAPTURE_GATE_DROP_CNT_EN
      drops   <= drops_nx;
`endif
    end
  end

  assign s_axis_tready = rdy;
  assign m_axis_tvalid = out_v;
  assign m_axis_tdata  = out_d;
  assign m_axis_tlast  = out_l;
  assign busy          = (state == ARMED) || (state == CAPTURE);
  assign cap_done      = done;
  assign overflow      = ovf;
`ifdef ADC_CAPTURE_GATE_DROP_CNT_EN
  assign drop_cnt      = drops;
`endif

endmodule

// File: tb/tb_adc_capture_gate.sv
// Directed bench for adc_capture_gate: sw/threshold triggers,
// back-pressure drops, abort and mid-capture reset.
module tb_adc_capture_gate;

  localparam int NS = 8;
  localparam int DW = 16 * NS;

  logic          rf_clk;
  logic          rf_rstb;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          arm;
  logic          abort;
  logic          sw_trig;
  logic          trig_mode;
  logic [15:0]   threshold;
  logic [31:0]   cap_beats;
  logic          busy;
  logic          cap_done;
  logic          overflow;
`ifdef ADC_CAPTURE_GATE_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [DW:0] rx[$];

  adc_capture_gate dut (
    .rf_clk       (rf_clk),
    .rf_rstb      (rf_rstb),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .arm          (arm),
    .abort        (abort),
    .sw_trig      (sw_trig),
    .trig_mode    (trig_mode),
    .threshold    (threshold),
    .cap_beats    (cap_beats),
    .busy         (busy),
    .cap_done     (cap_done),
    .overflow     (overflow)
`ifdef ADC_CAPTURE_GATE_DROP_CNT_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  initial rf_clk = 1'b0;
  always #5 rf_clk = ~rf_clk;

  always @(negedge rf_clk)
    if (rf_rstb && m_axis_tvalid && m_axis_tready)
      rx.push_back({m_axis_tlast, m_axis_tdata});

  function automatic logic [DW-1:0] beat(input int t);
    logic [DW-1:0] r;
    for (int i = 0; i < NS; i++) r[i*16 +: 16] = 16'(t * 16 + i);
    return r;
  endfunction

  function automatic logic [DW-1:0] fill(input logic [15:0] v);
    return {NS{v}};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [DW:0] obs,
                      input logic [DW:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic exp_rx(input string tag, input int i, input logic l,
                        input logic [DW-1:0] d);
    logic [DW:0] got;
    got = (i < rx.size()) ? rx[i] : 'x;
    chkd(tag, got, {l, d});
  endtask

  task automatic cyc();
    @(posedge rf_clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    cyc();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic do_arm(input logic [31:0] n);
    cap_beats = n;
    arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  task automatic trig();
    sw_trig = 1'b1;
    cyc();
    sw_trig = 1'b0;
  endtask

  initial begin
    rf_rstb = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    m_axis_tready = 1'b1;
    arm = 1'b0;
    abort = 1'b0;
    sw_trig = 1'b0;
    trig_mode = 1'b0;
    threshold = 16'd0;
    cap_beats = 32'd0;

    #12;
    chk1("rst_tvalid", m_axis_tvalid, 1'b0);
    chk1("rst_tlast", m_axis_tlast, 1'b0);
    chkd("rst_tdata", {1'b0, m_axis_tdata}, '0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", cap_done, 1'b0);
    chk1("rst_ovf", overflow, 1'b0);
    chk1("rst_sready", s_axis_tready, 1'b0);
    rf_rstb = 1'b1;
    cyc();
    chk1("sready_up", s_axis_tready, 1'b1);

    // software trigger, 4 beats
    rx.delete();
    do_arm(32'd4);
    chk1("t1_busy", busy, 1'b1);
    idle(2);
    trig();
    for (int t = 1; t <= 7; t++) send(beat(t));
    idle(4);
    chkn("t1_count", rx.size(), 4);
    exp_rx("t1_b1", 0, 1'b0, beat(1));
    exp_rx("t1_b2", 1, 1'b0, beat(2));
    exp_rx("t1_b3", 2, 1'b0, beat(3));
    exp_rx("t1_b4", 3, 1'b1, beat(4));
    chk1("t1_done", cap_done, 1'b1);
    chk1("t1_busy_end", busy, 1'b0);
    chk1("t1_ovf", overflow, 1'b0);

    // threshold trigger; 200 -> 300 across a boundary must not fire
    rx.delete();
    trig_mode = 1'b1;
    threshold = 16'd100;
    send(fill(16'd200));
    idle(1);
    do_arm(32'd2);
    chk1("t2_done_clr", cap_done, 1'b0);
    send(fill(16'd300));
    idle(3);
    chk1("t2_no_trig_busy", busy, 1'b1);
    chk1("t2_no_trig_out", m_axis_tvalid, 1'b0);
    send({16'd150, 16'd150, 16'd150, 16'd150,
          16'd50, 16'd30, 16'd20, 16'd10});
    send(fill(16'd150));
    send(fill(16'd160));
    idle(4);
    chkn("t2_count", rx.size(), 2);
    exp_rx("t2_b1", 0, 1'b0, {16'd150, 16'd150, 16'd150, 16'd150,
                              16'd50, 16'd30, 16'd20, 16'd10});
    exp_rx("t2_b2", 1, 1'b1, fill(16'd150));
    chk1("t2_done", cap_done, 1'b1);

    // crossing from previous beat's sample 7 into sample 0
    rx.delete();
    threshold = 16'd0;
    send(fill(-16'sd10));
    idle(1);
    do_arm(32'd1);
    idle(2);
    chk1("t3_wait_busy", busy, 1'b1);
    send(fill(16'd20));
    idle(4);
    chkn("t3_count", rx.size(), 1);
    exp_rx("t3_b1", 0, 1'b1, fill(16'd20));
    chk1("t3_done", cap_done, 1'b1);

    // back-pressure: 3 low cycles, 2 beats dropped
    rx.delete();
    trig_mode = 1'b0;
    do_arm(32'd8);
    idle(1);
    trig();
    send(beat(10));
    send(beat(11));
    send(beat(12));
    send(beat(13));
    m_axis_tready = 1'b0;
    send(beat(14));
    chkd("t4_hold1", {m_axis_tvalid, m_axis_tdata}, {1'b1, beat(12)});
    chk1("t4_ovf_mid", overflow, 1'b1);
    idle(1);
    chkd("t4_hold2", {m_axis_tvalid, m_axis_tdata}, {1'b1, beat(12)});
    send(beat(15));
    chkd("t4_hold3", {m_axis_tvalid, m_axis_tdata}, {1'b1, beat(12)});
    m_axis_tready = 1'b1;
    for (int t = 16; t <= 19; t++) send(beat(t));
    idle(4);
    chkn("t4_count", rx.size(), 6);
    exp_rx("t4_b1", 0, 1'b0, beat(10));
    exp_rx("t4_b3", 2, 1'b0, beat(12));
    exp_rx("t4_b4", 3, 1'b0, beat(15));
    exp_rx("t4_last", 5, 1'b1, beat(17));
    chk1("t4_ovf", overflow, 1'b1);
    chk1("t4_done", cap_done, 1'b1);
`ifdef ADC_CAPTURE_GATE_DROP_CNT_EN
    chkn("t4_drops", int'(drop_cnt), 2);
`endif

    // abort after beat 2 of 10
    rx.delete();
    do_arm(32'd10);
    chk1("t5_ovf_clr", overflow, 1'b0);
    idle(1);
    trig();
    send(beat(20));
    send(beat(21));
    send(beat(22));
    abort = 1'b1;
    send(beat(23));
    abort = 1'b0;
    chk1("t5_busy", busy, 1'b0);
    chk1("t5_tvalid", m_axis_tvalid, 1'b0);
    chk1("t5_tlast", m_axis_tlast, 1'b0);
    chk1("t5_done", cap_done, 1'b0);
    idle(2);
    begin
      int lasts;
      lasts = 0;
      foreach (rx[i]) if (rx[i][DW]) lasts++;
      chkn("t5_no_tlast", lasts, 0);
    end
    do_arm(32'd0);
    chk1("t5_zero_arm", busy, 1'b0);
    idle(2);
    chk1("t5_zero_arm2", busy, 1'b0);

    // reset in the middle of a capture
    do_arm(32'd10);
    idle(1);
    trig();
    send(beat(30));
    send(beat(31));
    send(beat(32));
    chk1("t6_pre_valid", m_axis_tvalid, 1'b1);
    #2;
    rf_rstb = 1'b0;
    #1;
    chk1("t6_tvalid", m_axis_tvalid, 1'b0);
    chk1("t6_busy", busy, 1'b0);
    chk1("t6_sready", s_axis_tready, 1'b0);
    chk1("t6_tlast", m_axis_tlast, 1'b0);
    chkd("t6_tdata", {1'b0, m_axis_tdata}, '0);
    chk1("t6_ovf", overflow, 1'b0);
    chk1("t6_done", cap_done, 1'b0);
    #3;
    rf_rstb = 1'b1;
    cyc();
    rx.delete();
    do_arm(32'd3);
    idle(1);
    trig();
    for (int t = 40; t <= 44; t++) send(beat(t));
    idle(4);
    chkn("t6_count", rx.size(), 3);
    exp_rx("t6_b1", 0, 1'b0, beat(40));
    exp_rx("t6_b3", 2, 1'b1, beat(42));
    chk1("t6_redone", cap_done, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
